// File: rtl/rf_read_arbiter.sv
// Register file with one write port and one read port shared by NREQ requesters.
// A round-robin arbiter picks the requester; data returns one cycle later in a stallable response register.
module rf_read_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 1,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*AW-1:0]  req_addr,
   output logic [NREQ-1:0]     req_ready,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [IDW-1:0]      resp_id,
   output logic [DW-1:0]       resp_data,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [DW-1:0]       wdata
);

   logic [DW-1:0]  mem [0:(2**AW)-1];
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] ptr_next;
   logic           grant_any;
   logic           can_issue;
   logic [AW-1:0]  grant_addr;

   assign can_issue = !resp_valid || resp_ready;

   // Search starts at ptr and wraps modulo NREQ; first valid requester wins.
   always_comb begin
      int cand;
      grant_any = 1'b0;
      grant_idx = '0;
      req_ready = '0;
      cand      = 0;
      if (!reset && can_issue) begin
         for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ)
               cand = cand - NREQ;
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = IDW'(cand);
            end
         end
      end
      if (grant_any)
         req_ready[grant_idx] = 1'b1;
   end

   assign ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   assign grant_addr = req_addr[int'(grant_idx)*AW +: AW];

   // Storage is not reset; writes proceed even while reset is asserted.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // The read samples mem before this edge's write lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
      end else if (grant_any) begin
         ptr        <= ptr_next;
         resp_valid <= 1'b1;
         resp_id    <= grant_idx;
         resp_data  <= mem[grant_addr];
      end else if (can_issue) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter: a reference model predicts grants and
// queues the expected responses, which are compared as the DUT presents them.
module tb_rf_read_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 1;
   localparam int IDW  = 2;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ-1:0]     req_ready;
   logic                resp_valid;
   logic                resp_ready;
   logic [IDW-1:0]      resp_id;
   logic [DW-1:0]       resp_data;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [DW-1:0]       wdata;

   logic [AW-1:0]       addr [NREQ];

   rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_addr = '0;
      for (int i = 0; i < NREQ; i++)
         req_addr[i*AW +: AW] = addr[i];
   end

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
   } resp_t;

   resp_t         sb[$];
   int            mptr;
   logic [DW-1:0] mmem [2**AW];
   int            checks   = 0;
   int            failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_grant();
      int c;
      if (reset) return -1;
      if (sb.size() != 0 && !resp_ready) return -1;
      for (int k = 0; k < NREQ; k++) begin
         c = (mptr + k) % NREQ;
         if (req_valid[c]) return c;
      end
      return -1;
   endfunction

   // Check at negedge, then advance the model at the posedge alongside the DUT.
   task automatic cycle(input string tag);
      int g;
      logic [NREQ-1:0] er;
      @(negedge clk);
      g  = exp_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check_eq({tag, " req_ready"}, 32'(req_ready), 32'(er));
      check_eq({tag, " resp_valid"}, 32'(resp_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         check_eq({tag, " resp_id"}, 32'(resp_id), 32'(sb[0].id));
         check_eq({tag, " resp_data"}, 32'(resp_data), 32'(sb[0].data));
      end
      @(posedge clk);
      if (reset) begin
         sb.delete();
         mptr = 0;
      end else begin
         if (sb.size() != 0 && resp_ready) void'(sb.pop_front());
         if (g >= 0) begin
            sb.push_back('{id: IDW'(g), data: mmem[addr[g]]});
            mptr = (g + 1) % NREQ;
         end
      end
      if (we) mmem[waddr] = wdata;
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = '1;
      resp_ready = 1'b1;
      we         = 1'b0;
      waddr      = '0;
      wdata      = '0;
      mptr       = 0;
      for (int i = 0; i < NREQ; i++) addr[i] = AW'(i);

      cycle("reset");
      cycle("reset");
      check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
      check_eq("rst resp_id", 32'(resp_id), 32'd0);
      check_eq("rst resp_data", 32'(resp_data), 32'd0);

      reset     = 1'b0;
      req_valid = '0;
      we        = 1'b1;
      for (int a = 0; a < 2**AW; a++) begin
         waddr = AW'(a);
         if (a == 5)                wdata = 1'b1;
         else if (a == 6 || a == 9) wdata = 1'b0;
         else                       wdata = DW'($urandom_range(0, 1));
         cycle("init");
      end
      we = 1'b0;

      req_valid = 4'b0001; addr[0] = 8'd5;
      cycle("basic5");
      addr[0] = 8'd6;
      cycle("basic6");
      req_valid = '0;
      cycle("basic_drain");

      req_valid = 4'b1000;
      cycle("rr_align");
      req_valid = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < NREQ; i++) addr[i] = AW'($urandom_range(0, 255));
         cycle("rr");
      end
      req_valid = '0;
      cycle("rr_drain");

      req_valid = 4'b0100;
      cycle("wrap_set");
      req_valid = 4'b0101;
      cycle("wrap0");
      cycle("wrap2");
      req_valid = '0;
      cycle("wrap_drain");

      req_valid = 4'b0001; addr[0] = 8'd20;
      cycle("bp_grant");
      resp_ready = 1'b0;
      req_valid  = 4'b1111;
      for (int n = 0; n < 3; n++) begin
         we    = (n == 1);
         waddr = 8'd20;
         wdata = ~mmem[20];
         cycle("bp_stall");
      end
      we         = 1'b0;
      resp_ready = 1'b1;
      cycle("bp_resume");
      req_valid = '0;
      cycle("bp_drain");

      req_valid = 4'b0001; addr[0] = 8'd9;
      we = 1'b1; waddr = 8'd9; wdata = 1'b1;
      cycle("rbw_same");
      we = 1'b0;
      cycle("rbw_after");
      req_valid = '0;
      cycle("rbw_drain");

      req_valid = 4'b0010; addr[1] = 8'd33;
      cycle("mid_set");
      reset = 1'b1;
      req_valid = 4'b1111;
      we = 1'b1; waddr = 8'd33; wdata = ~mmem[33];
      cycle("mid_reset");
      reset = 1'b0;
      we    = 1'b0;
      for (int i = 0; i < NREQ; i++) addr[i] = 8'd33;
      cycle("mid_release");
      cycle("mid_next");
      req_valid = '0;
      cycle("mid_drain");

      for (int n = 0; n < 400; n++) begin
         req_valid  = NREQ'($urandom_range(0, 2**NREQ - 1));
         resp_ready = ($urandom_range(0, 3) != 0);
         we         = $urandom_range(0, 1);
         waddr      = AW'($urandom_range(0, 15));
         wdata      = DW'($urandom_range(0, 1));
         reset      = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < NREQ; i++) addr[i] = AW'($urandom_range(0, 15));
         cycle("rand");
      end
      reset      = 1'b0;
      we         = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b1;
      cycle("final");
      cycle("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
